// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types, default geometry and width helpers for the fifo write-port arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 14;
    localparam int DEF_FIFO_DEPTH = 64;
    localparam int DEF_MAX_BURST  = 8;
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction
    localparam int OCC_W = occ_w(DEF_FIFO_DEPTH);
    localparam int ID_W  = id_w(DEF_NUM_REQ);
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request bus plus the fifo write/read strobes seen by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_rd_en;
    modport master (output req, req_data, req_last, fifo_rd_en, input gnt, fifo_wr_en, fifo_wr_data);
    modport slave  (input req, req_data, req_last, fifo_rd_en, output gnt, fifo_wr_en, fifo_wr_data);
endinterface

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: combinational round-robin first-one finder starting at rr_ptr and wrapping.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] sel,
    output logic          found
);
    always_comb begin
        sel = rr_ptr;
        found = 1'b0;
        // Descending scan so the candidate closest to rr_ptr is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(rr_ptr) + i) % N;
            if (req[idx]) begin
                sel = IW'(idx);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-locked round-robin sharing of one fifo write port, with its own
// committed-occupancy count so the fifo is never written while full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_wr_arbiter_if.slave              bus,
    output logic [occ_w(FIFO_DEPTH)-1:0]  occupancy,
    output logic [id_w(NUM_REQ)-1:0]      owner,
    output logic                          busy,
    output logic                          underrun_err
);
    localparam int OW = occ_w(FIFO_DEPTH);
    localparam int IW = id_w(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    state_t                state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel, cur, nxt;
    logic [BW-1:0]         beat_q, beat_d, beat_inc;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  wr_en_q, wr_en_d, underrun_q, underrun_d;
    logic [FIFO_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  found, accept, last, can_write, done, rd_v;

    rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (.req(bus.req), .rr_ptr(rr_ptr_q), .sel(sel), .found(found));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_q     <= '0;
            occ_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_q     <= beat_d;
            occ_q      <= occ_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            underrun_q <= underrun_d;
        end
    end

    // A read in the same cycle deliberately does not free a slot for this cycle's grant.
    always_comb begin
        can_write = occ_q < OW'(FIFO_DEPTH);
        cur = (state_q == IDLE) ? sel : owner_q;
        accept = !rst && can_write && ((state_q == IDLE) ? found : bus.req[owner_q]);
        bus.gnt = accept ? (NUM_REQ'(1) << cur) : '0;
        last = bus.req_last[cur];
        busy = state_q == BURST;
        owner = owner_q;
        occupancy = occ_q;
        underrun_err = underrun_q;
        bus.fifo_wr_en = wr_en_q;
        bus.fifo_wr_data = wr_data_q;
    end

    // In IDLE beat_q is 0, so beat_inc hits MAX_BURST on the first word only when MAX_BURST==1.
    always_comb begin
        nxt = (cur == IW'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
        beat_inc = beat_q + BW'(accept);
        done = accept && (last || beat_inc == BW'(MAX_BURST));
        state_d = done ? IDLE : ((state_q == BURST || found) ? BURST : IDLE);
        owner_d = (state_q == BURST || found) ? cur : owner_q;
        rr_ptr_d = done ? nxt : rr_ptr_q;
        beat_d = done ? '0 : beat_inc;
    end

    always_comb begin
        rd_v = bus.fifo_rd_en && occ_q != '0;
        occ_d = occ_q + OW'(accept) - OW'(rd_v);
        underrun_d = underrun_q | (bus.fifo_rd_en && occ_q == '0);
        wr_en_d = accept;
        wr_data_d = accept ? bus.req_data[cur*FIFO_WIDTH +: FIFO_WIDTH] : wr_data_q;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a write-data scoreboard and an occupancy/underrun model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [OCC_W-1:0] occupancy;
    logic [ID_W-1:0] owner;
    logic busy, underrun_err;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(14)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(14), .FIFO_DEPTH(64), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .occupancy(occupancy),
        .owner(owner), .busy(busy), .underrun_err(underrun_err)
    );

    int n_checks = 0;
    int n_fail = 0;
    int exp_occ = 0;
    logic exp_under = 1'b0;
    logic [11:0] cnt = 12'h011;
    logic [13:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every registered write must match the oldest word the bench expected to be accepted.
    always @(negedge clk) begin
        if (bus.fifo_wr_en !== 1'b0) begin
            if (sb.size() == 0) check("wr_en_unexpected", 32'(bus.fifo_wr_en), 32'd0);
            else check("wr_data", 32'(bus.fifo_wr_data), 32'(sb.pop_front()));
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rd, input logic [3:0] eg);
        bus.req = r;
        bus.req_last = l;
        bus.fifo_rd_en = rd;
        for (int i = 0; i < 4; i++) bus.req_data[i*14 +: 14] = 14'((i << 12) | int'(cnt));
        #1 check("gnt", 32'(bus.gnt), 32'(eg));
        for (int i = 0; i < 4; i++) if (eg[i]) sb.push_back(14'((i << 12) | int'(cnt)));
        cnt++;
        if (rd && exp_occ == 0) exp_under = 1'b1;
        exp_occ = exp_occ + (eg != 4'b0 ? 1 : 0) - ((rd && exp_occ > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        check("occupancy", 32'(occupancy), 32'(exp_occ));
        check("underrun", 32'(underrun_err), 32'(exp_under));
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.req_last = '0;
        bus.fifo_rd_en = 1'b0;
        bus.req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_underrun", 32'(underrun_err), 32'd0);
        rst = 1'b0;
        // Three-word burst from requester 0.
        cyc(4'b0001, 4'b0000, 1'b0, 4'b0001);
        check("burst_busy", 32'(busy), 32'd1);
        cyc(4'b0001, 4'b0000, 1'b0, 4'b0001);
        cyc(4'b0001, 4'b0001, 1'b0, 4'b0001);
        check("burst_end_busy", 32'(busy), 32'd0);
        check("burst_owner", 32'(owner), 32'd0);
        // rr_ptr is now 1, so requester 1 beats requester 0; then steer rr_ptr back to 0.
        cyc(4'b0011, 4'b0011, 1'b0, 4'b0010);
        cyc(4'b1000, 4'b1000, 1'b0, 4'b1000);
        for (int b = 0; b < 5; b++) begin
            cyc(4'b1111, 4'b0000, 1'b0, 4'b0001 << (b % 4));
            cyc(4'b1111, 4'b1111, 1'b0, 4'b0001 << (b % 4));
        end
        check("rr_owner", 32'(owner), 32'd0);
        // Unterminated burst: forced re-arbitration after 8 words, then an immediate re-grant.
        for (int k = 0; k < 8; k++) cyc(4'b0100, 4'b0000, 1'b0, 4'b0100);
        check("max_burst_idle", 32'(busy), 32'd0);
        cyc(4'b0100, 4'b0000, 1'b0, 4'b0100);
        check("regrant_busy", 32'(busy), 32'd1);
        cyc(4'b0100, 4'b0100, 1'b0, 4'b0100);
        check("regrant_owner", 32'(owner), 32'd2);
        // Fill to capacity, stall, and resume after one read.
        while (exp_occ < 64) cyc(4'b0001, 4'b0001, 1'b0, 4'b0001);
        cyc(4'b0001, 4'b0001, 1'b0, 4'b0000);
        check("full_occ", 32'(occupancy), 32'd64);
        cyc(4'b0001, 4'b0001, 1'b1, 4'b0000);
        cyc(4'b0001, 4'b0001, 1'b0, 4'b0001);
        while (exp_occ > 10) cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
        cyc(4'b0001, 4'b0001, 1'b1, 4'b0001);
        check("simul_occ", 32'(occupancy), 32'd10);
        while (exp_occ > 0) cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
        check("underrun_set", 32'(underrun_err), 32'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
        check("underrun_sticky", 32'(underrun_err), 32'd1);
        // Reset at beat 4 drops the in-flight word and the owner.
        repeat (4) cyc(4'b0010, 4'b0000, 1'b0, 4'b0010);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        exp_occ = 0;
        exp_under = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'b1111, 4'b1111, 1'b0, 4'b0001);
        cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
        @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one fifo instance between NUM_REQ producers using round-robin arbitration.
- Grants are burst-locked: one owner keeps the port until it sends its last word or reaches MAX_BURST words.
- Keeps its own committed-occupancy count, sized to represent the full value, so the FIFO is never overwritten when full.
- Sits directly in front of fifo.wr_en/wr_data; observes the consumer's fifo.rd_en.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- FIFO_WIDTH, 14, data word width; matches the fifo instance.
- FIFO_DEPTH, 64, FIFO capacity in words; power of two.
- MAX_BURST, 8, maximum words per grant before forced re-arbitration (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-producer word-valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  packed producer data; slice i belongs to requester i.
- req_last  in  NUM_REQ  marks the final word of the producer's burst.
- gnt  out  NUM_REQ  word accepted from requester i this cycle; combinational, at most one bit high.
- fifo_wr_en  out  1  registered write strobe to the fifo.
- fifo_wr_data  out  FIFO_WIDTH  registered write data to the fifo.
- fifo_rd_en  in  1  consumer read strobe, observed only.
- occupancy  out  $clog2(FIFO_DEPTH)+1  committed word count.
- owner  out  $clog2(NUM_REQ)  current or last burst owner.
- busy  out  1  high in BURST state.
- underrun_err  out  1  sticky; set when fifo_rd_en arrives with occupancy==0.

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, owner=0, beat=0, occupancy=0, fifo_wr_en=0, fifo_wr_data=0, underrun_err=0. gnt is forced to 0 while rst is high.
- can_write = (occupancy < FIFO_DEPTH). fifo_rd_en in the same cycle does not free a slot; this keeps the check conservative.
- Occupancy update per cycle, from accept (any gnt bit) and rd_v (fifo_rd_en && occupancy>0):
  - accept only: +1.
  - rd_v only: -1.
  - both or neither: unchanged.
  - fifo_rd_en with occupancy==0: ignored, and underrun_err is set.
- Write latency: a word accepted at edge N appears as fifo_wr_en=1 with its data during cycle N+1. fifo_wr_en is high exactly one cycle per accepted word.
- IDLE:
  - sel = first i with req[i]=1, searching from rr_ptr upward and wrapping.
  - If a requester is found: owner<=sel and gnt[sel]=can_write.
  - If that word is accepted with req_last=1, or MAX_BURST==1: stay IDLE and set rr_ptr<=sel+1 (mod NUM_REQ).
  - Otherwise: go to BURST. beat is 1 if the first word was accepted, else 0.
- BURST:
  - gnt[owner]=req[owner]&&can_write.
  - Each accepted word increments beat.
  - Return to IDLE with rr_ptr<=owner+1 when the accepted word has req_last=1 or beat reaches MAX_BURST; beat<=0.
- Stalls: if the owner drops req mid-burst, or can_write=0, the grant is held. No timeout, and other requesters stay blocked.
- req_last on a non-accepted cycle has no effect.
- Wrap: rr_ptr and the search index wrap modulo NUM_REQ; the beat counter is $clog2(MAX_BURST)+1 bits.
- Reset mid-burst: the in-flight registered word is dropped (fifo_wr_en=0) and the owner is lost. Producers must resend.

Decomposition:
- Package fifo_arb_pkg holds the state enum (IDLE, BURST) and the helper widths OCC_W=$clog2(FIFO_DEPTH)+1 and ID_W=$clog2(NUM_REQ).
- One sub-module, rr_select: combinational round-robin first-one finder. Inputs are req and rr_ptr; outputs are sel and found.

Test Plan:
- Reset, then req=4'b0001 with req_last on the 3rd word, data 0x11,0x12,0x13 -> gnt[0] for 3 cycles; fifo_wr_en 3 cycles, each one cycle later; occupancy=3; back to IDLE; rr_ptr=1.
- req=4'b1111, all bursts 2 words with req_last on word 2 -> grant order 0,1,2,3,0 at 2 words each; gnt one-hot every cycle.
- Single requester holds req with no req_last, MAX_BURST=8 -> 8 words, re-arbitration; with only it requesting, re-granted after 1 IDLE-accept cycle; no gap in gnt.
- Fill to 64 with no reads -> gnt low at occupancy=64. One fifo_rd_en -> occupancy=63, and a grant resumes on the next cycle.
- Simultaneous accept and fifo_rd_en at occupancy=10 -> occupancy stays 10. fifo_rd_en at occupancy=0 -> underrun_err=1 and stays 1.
- Assert rst mid-burst (beat=4) -> in the same cycle gnt=0, fifo_wr_en=0, occupancy=0, state IDLE. After release, the next grant starts at requester 0.
